// File: rtl/wind_pkg.sv
// Shared types and LED pattern constants for the wind pattern controller.
package wind_pkg;

  typedef enum logic [1:0] {
    CALM          = 2'b00,
    RIGHT_TO_LEFT = 2'b01,
    LEFT_TO_RIGHT = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    CALM_A = 3'd0,
    CALM_B = 3'd1,
    P0     = 3'd2,
    P1     = 3'd3,
    P2     = 3'd4
  } state_e;

  localparam logic [2:0] PAT_BOTH  = 3'b101;
  localparam logic [2:0] PAT_MID   = 3'b010;
  localparam logic [2:0] PAT_LEFT  = 3'b100;
  localparam logic [2:0] PAT_RIGHT = 3'b001;

  // The reserved switch code 11 behaves exactly like CALM.
  function automatic mode_e decode_mode(input logic [1:0] sw);
    mode_e m;
    unique case (sw)
      2'b01:   m = RIGHT_TO_LEFT;
      2'b10:   m = LEFT_TO_RIGHT;
      default: m = CALM;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clock cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  // Gated by reset so tick reads 0 while reset is held, even when TICK_DIV == 1.
  assign tick   = w_last & ~reset;

  // Count 0..TICK_DIV-1 and wrap; with TICK_DIV == 1 the count stays at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/wind_pattern_ctrl.sv
// Wind pattern controller: synchronised mode switches drive a Moore LED FSM
// that advances one step per prescaler tick.
module wind_pattern_ctrl
  import wind_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] SW,
  output logic [2:0] LEDR,
  output logic       tick
);

  logic [1:0] r_sw_meta;
  logic [1:0] r_sw_s;
  mode_e      w_mode;
  state_e     r_state;
  state_e     w_state_next;
  logic       w_tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign tick   = w_tick;
  assign w_mode = decode_mode(r_sw_s);

  // Two-flop synchroniser for the raw switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= 2'b00;
      r_sw_s    <= 2'b00;
    end else begin
      r_sw_meta <= SW;
      r_sw_s    <= r_sw_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CALM_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: step only on tick; unreachable encodings fall back to CALM_A at once.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CALM_A, CALM_B, P0, P1, P2: begin
        if (w_tick) begin
          unique case (w_mode)
            LEFT_TO_RIGHT: begin
              case (r_state)
                P0:      w_state_next = P1;
                P1:      w_state_next = P2;
                default: w_state_next = P0;
              endcase
            end
            RIGHT_TO_LEFT: begin
              case (r_state)
                P2:      w_state_next = P1;
                P1:      w_state_next = P0;
                default: w_state_next = P2;
              endcase
            end
            default: begin
              w_state_next = (r_state == CALM_A) ? CALM_B : CALM_A;
            end
          endcase
        end
      end
      default: w_state_next = CALM_A;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    LEDR = PAT_BOTH;
    case (r_state)
      CALM_A:  LEDR = PAT_BOTH;
      CALM_B:  LEDR = PAT_MID;
      P0:      LEDR = PAT_LEFT;
      P1:      LEDR = PAT_MID;
      P2:      LEDR = PAT_RIGHT;
      default: LEDR = PAT_BOTH;
    endcase
  end

endmodule

// File: tb/tb_wind_pattern_ctrl.sv
// Directed, table-driven bench for wind_pattern_ctrl (TICK_DIV = 4 and 1).
module tb_wind_pattern_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] SW;
  logic [2:0] ledr4;
  logic       tick4;
  logic [2:0] ledr1;
  logic       tick1;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [1:0] sw;
    int         n;     // cycles to advance before comparing (0 = no clock edge)
    logic [2:0] ledr;
    logic       tick;
    string      name;
  } vec_t;

  vec_t vecs[$];

  wind_pattern_ctrl #(
    .TICK_DIV (4)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .LEDR  (ledr4),
    .tick  (tick4)
  );

  wind_pattern_ctrl #(
    .TICK_DIV (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .LEDR  (ledr1),
    .tick  (tick1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] sw, input int n,
                     input logic [2:0] ledr, input logic tick, input string name);
    vec_t v;
    v.rst = rst; v.sw = sw; v.n = n; v.ledr = ledr; v.tick = tick; v.name = name;
    vecs.push_back(v);
  endtask

  logic [2:0] exp1[6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    SW      = 2'b00;

    // Calm mode after reset: ticks at edges 3/7/11 (count 3), state moves on edges 4/8/12.
    add(1, 2'b00, 2, 3'b101, 0, "calm_reset_held");
    add(0, 2'b00, 0, 3'b101, 0, "calm_release");
    add(0, 2'b00, 1, 3'b101, 0, "calm_e1");
    add(0, 2'b00, 1, 3'b101, 0, "calm_e2");
    add(0, 2'b00, 1, 3'b101, 1, "calm_e3_tick");
    add(0, 2'b00, 1, 3'b010, 0, "calm_e4");
    add(0, 2'b00, 3, 3'b010, 1, "calm_e7_tick");
    add(0, 2'b00, 1, 3'b101, 0, "calm_e8");
    add(0, 2'b00, 4, 3'b010, 0, "calm_e12");
    // Left-to-right held from reset.
    add(1, 2'b10, 2, 3'b101, 0, "lr_reset_held");
    add(0, 2'b10, 0, 3'b101, 0, "lr_release");
    add(0, 2'b10, 3, 3'b101, 1, "lr_e3_tick");
    add(0, 2'b10, 1, 3'b100, 0, "lr_e4_p0");
    add(0, 2'b10, 4, 3'b010, 0, "lr_e8_p1");
    add(0, 2'b10, 3, 3'b010, 1, "lr_e11_tick");
    add(0, 2'b10, 1, 3'b001, 0, "lr_e12_p2");
    add(0, 2'b10, 4, 3'b100, 0, "lr_e16_p0");
    add(0, 2'b10, 4, 3'b010, 0, "lr_e20_p1");
    // Reversal from P1, then a late switch back that must be ignored for one tick.
    add(0, 2'b01, 4, 3'b100, 0, "rev_e24_p0");
    add(0, 2'b01, 4, 3'b001, 0, "rl_e28_p2");
    add(0, 2'b01, 4, 3'b010, 0, "rl_e32_p1");
    add(0, 2'b01, 2, 3'b010, 0, "rl_e34_hold");
    add(0, 2'b10, 1, 3'b010, 1, "late_e35_tick");
    add(0, 2'b10, 1, 3'b100, 0, "late_e36_ignored");
    add(0, 2'b10, 4, 3'b010, 0, "late_e40_lr");
    // Reserved code 11 behaves as calm.
    add(0, 2'b11, 4, 3'b101, 0, "rsv_e44");
    add(0, 2'b11, 4, 3'b010, 0, "rsv_e48");
    add(0, 2'b11, 4, 3'b101, 0, "rsv_e52");
    // Reset mid-step at P2 with count 2, then a fresh count after release.
    add(1, 2'b10, 1, 3'b101, 0, "mid_pre_reset");
    add(0, 2'b10, 12, 3'b001, 0, "mid_e12_p2");
    add(0, 2'b10, 2, 3'b001, 0, "mid_e14_cnt2");
    add(1, 2'b10, 0, 3'b101, 0, "mid_async_reset");
    add(0, 2'b10, 3, 3'b101, 1, "mid_rel_e3_tick");
    add(0, 2'b10, 1, 3'b100, 0, "mid_rel_e4_p0");

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      SW    = vecs[i].sw;
      repeat (vecs[i].n) @(negedge clk);
      #1;
      check({vecs[i].name, "_ledr"}, ledr4, vecs[i].ledr);
      check({vecs[i].name, "_tick"}, {2'b00, tick4}, {2'b00, vecs[i].tick});
    end

    // TICK_DIV = 1: sync latency gives two calm steps before the LR walk starts.
    exp1[0] = 3'b010;
    exp1[1] = 3'b101;
    exp1[2] = 3'b100;
    exp1[3] = 3'b010;
    exp1[4] = 3'b001;
    exp1[5] = 3'b100;
    reset = 1'b1;
    SW    = 2'b10;
    @(negedge clk);
    #1;
    check("div1_reset_tick", {2'b00, tick1}, 3'b000);
    check("div1_reset_ledr", ledr1, 3'b101);
    reset = 1'b0;
    #1;
    check("div1_release_tick", {2'b00, tick1}, 3'b001);
    check("div1_release_ledr", ledr1, 3'b101);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("div1_e%0d_ledr", k + 1), ledr1, exp1[k]);
      check($sformatf("div1_e%0d_tick", k + 1), {2'b00, tick1}, 3'b001);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wind_pattern_ctrl.md
WIND_PATTERN_CTRL -- requirements
Module: wind_pattern_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clock cycles per pattern step (legal range 1..2^26; 25_000_000 on board).
REQ-002 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SW  input  2  raw (unsynchronized) mode switches.
REQ-005 SHALL have port LEDR  output  3  LED pattern, bit 2 = leftmost LED.
REQ-006 SHALL have port tick  output  1  one-cycle pulse marking each pattern step (debug/observability).

Function
REQ-007 SHALL pass SW through a two-flop synchronizer; decoding uses only the second stage (sw_s), giving 2-cycle input latency.
REQ-008 SHALL decode sw_s: 00 = CALM, 01 = RIGHT_TO_LEFT, 10 = LEFT_TO_RIGHT, 11 = reserved, behaving exactly as CALM.
REQ-009 SHALL contain a prescaler counting 0..TICK_DIV-1, with width max(1, clog2(TICK_DIV)).
REQ-010 SHALL assert tick for exactly one cycle when count == TICK_DIV-1; count then wraps to 0 on the next edge.
REQ-011 SHALL assert tick every cycle and hold count at 0 when TICK_DIV == 1.
REQ-012 SHALL implement a 5-state Moore FSM with states CALM_A (LEDR 101), CALM_B (010), P0 (100), P1 (010) and P2 (001).
REQ-013 SHALL change FSM state only on a cycle where tick is 1, and hold state otherwise.
REQ-014 SHALL, in CALM mode at tick, go CALM_A->CALM_B and any other state->CALM_A.
REQ-015 SHALL, in LEFT_TO_RIGHT mode at tick, go P0->P1->P2->P0, and CALM_A/CALM_B->P0.
REQ-016 SHALL, in RIGHT_TO_LEFT mode at tick, go P2->P1->P0->P2, and CALM_A/CALM_B->P2.
REQ-017 SHALL sample mode (sw_s) on the tick cycle only, so an SW change between ticks takes effect at the first tick at least 2 cycles after the change.
REQ-018 SHALL, on a mode reversal (LR<->RL), take the direction step from the current P state (e.g. at P1 an LR->RL switch gives P0), with no restart.
REQ-019 SHALL drive LEDR as a pure function of the registered state (Moore, no SW-to-LEDR combinational path); LEDR updates the cycle after the tick.
REQ-020 SHALL never drive LEDR with a value outside {101, 010, 100, 001}; any unreachable state encoding recovers to CALM_A on the next clock edge.

Reset
REQ-021 SHALL, on reset assertion, immediately (asynchronously) set state = CALM_A, LEDR = 101, count = 0, tick = 0 and both synchronizer stages = 00.
REQ-022 SHALL, on reset deassertion, start counting from 0, with the first tick at the TICK_DIV-th rising edge after release.
REQ-023 SHALL abandon any partially counted step on reset mid-operation; no pending transition survives reset.

Structure
REQ-024 SHALL take the mode enum (CALM, RIGHT_TO_LEFT, LEFT_TO_RIGHT), the state enum and the four 3-bit pattern constants from a shared package, wind_pkg.
REQ-025 SHALL implement the prescaler as sub-module tick_gen (params TICK_DIV; ports clk, reset, tick); the synchronizer, decode, FSM and output logic stay in wind_pattern_ctrl.

Verification (TICK_DIV = 4)
REQ-026 SHALL cover: reset held, SW = 00 -> LEDR = 101 and tick = 0; after release, tick at edges 4, 8, 12 -> LEDR 010, 101, 010.
REQ-027 SHALL cover: SW = 10 held from reset -> LEDR sequence 101, 100, 010, 001, 100, changing once per 4 cycles.
REQ-028 SHALL cover: SW = 01 from state P1, then SW = 10 applied 1 cycle before a tick -> the change is ignored at that tick (P1->P0), and the next tick gives P0->P1.
REQ-029 SHALL cover: SW = 11 -> LEDR alternates 101/010, identical to SW = 00.
REQ-030 SHALL cover: reset asserted mid-step (count = 2, state P2) -> LEDR = 101 in the same cycle without a clock edge; the first tick after release is at edge 4.
REQ-031 SHALL cover: TICK_DIV = 1 with SW = 10 -> tick constantly 1 and LEDR steps 100, 010, 001 on consecutive cycles.
